// File: rtl/gol_pkg.sv
// Shared definitions for the cell-array readout path.
//   state_e   : readout FSM encoding (ST_IDLE / ST_SEND)
//   row_w()   : width of a row index for a given row count (never below 1)
//   frame_bit(): flat bit position of (row, col); bit r*WIDTH+c is row r, column c,
//                the same ordering the array top level uses to pack its status bits.
package gol_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int row_w(input int height);
        return (height <= 1) ? 1 : $clog2(height);
    endfunction

    function automatic int frame_bit(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/grid_row_sel.sv
// Combinational row mux: picks one WIDTH-bit row out of a flattened frame.
//   snap_i : WIDTH*HEIGHT frame, bit r*WIDTH+c = row r, column c
//   row_i  : row index
//   row_o  : selected row, bit c = column c (zero for an index beyond HEIGHT-1)
module grid_row_sel
    import gol_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ROW_W  = 3
) (
    input  logic [WIDTH*HEIGHT-1:0] snap_i,
    input  logic [ROW_W-1:0]        row_i,
    output logic [WIDTH-1:0]        row_o
);

    always_comb begin
        row_o = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (row_i == ROW_W'(r)) begin
                row_o = snap_i[frame_bit(r, 0, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/grid_readout.sv
// Snapshots the cell array status once per generation and streams it out one
// row per beat over valid/ready, so the array can keep evolving while the
// previous generation drains.
//   clk, _rst   : clock (rising edge), asynchronous active-low reset
//   grid_status : cell status, bit r*WIDTH+c = row r, column c
//   gen_tick    : fresh generation present on grid_status this cycle
//   out_ready   : consumer accepts current beat
//   ovr_clr     : clears the sticky overrun flag
//   out_valid, out_data, out_row, out_last : row stream
//   gen_count   : frames captured since reset (wraps)
//   busy        : frame in flight
//   overrun     : sticky, a gen_tick was dropped
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no frame held; waiting for gen_tick to capture one
// ST_SEND | snapshot held; presenting row row_q until the last beat goes
module grid_readout
    import gol_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  HEIGHT = 8,
    parameter int  GEN_W  = 16,
    localparam int ROW_W  = row_w(HEIGHT)
) (
    input  logic                    clk,
    input  logic                    _rst,
    input  logic [WIDTH*HEIGHT-1:0] grid_status,
    input  logic                    gen_tick,
    input  logic                    out_ready,
    input  logic                    ovr_clr,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    out_last,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    busy,
    output logic                    overrun
);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [WIDTH*HEIGHT-1:0] snap_q, snap_d;
    logic [GEN_W-1:0]        gen_q, gen_d;
    logic                    ovr_q, ovr_d;

    logic last_row, xfer, fin_xfer, capture, drop;

    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    assign xfer     = (state_q == ST_SEND) && out_ready;
    assign fin_xfer = xfer && last_row;
    // A tick is taken when nothing is held, or when the held frame's final
    // beat leaves on the same edge (back-to-back, no bubble); otherwise dropped.
    assign capture  = gen_tick && ((state_q == ST_IDLE) || fin_xfer);
    assign drop     = gen_tick && (state_q == ST_SEND) && !fin_xfer;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap_d  = snap_q;
        gen_d   = gen_q;
        if (capture) begin
            snap_d  = grid_status;
            row_d   = '0;
            gen_d   = gen_q + GEN_W'(1);
            state_d = ST_SEND;
        end else if (fin_xfer) begin
            row_d   = '0;
            state_d = ST_IDLE;
        end else if (xfer) begin
            row_d   = row_q + ROW_W'(1);
        end
        // set beats clear when both land on the same cycle
        ovr_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            gen_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
            gen_q   <= gen_d;
            ovr_q   <= ovr_d;
        end
    end

    grid_row_sel #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ROW_W  (ROW_W)
    ) u_row_sel (
        .snap_i (snap_q),
        .row_i  (row_q),
        .row_o  (out_data)
    );

    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign out_row   = row_q;
    assign out_last  = (state_q == ST_SEND) && last_row;
    assign gen_count = gen_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_grid_readout.sv
module tb_grid_readout;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int GEN_W  = 4;
    localparam int ROW_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_b;
    logic [WIDTH*HEIGHT-1:0] grid_status;
    logic                    gen_tick;
    logic                    out_ready;
    logic                    ovr_clr;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [ROW_W-1:0]        out_row;
    logic                    out_last;
    logic [GEN_W-1:0]        gen_count;
    logic                    busy;
    logic                    overrun;

    grid_readout #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .GEN_W(GEN_W)) dut (
        .clk         (clk),
        ._rst        (rst_b),
        .grid_status (grid_status),
        .gen_tick    (gen_tick),
        .out_ready   (out_ready),
        .ovr_clr     (ovr_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .gen_count   (gen_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of beats still owed to the consumer.
    typedef struct {
        logic [WIDTH-1:0] d;
        int               row;
        bit               last;
    } beat_t;

    beat_t mq[$];
    int    m_gen;
    bit    m_ovr;
    bit    cmp_en = 0;

    always @(posedge clk or negedge rst_b) begin : model
        bit held;
        bit fin;
        if (!rst_b) begin
            mq.delete();
            m_gen = 0;
            m_ovr = 0;
        end else begin
            held = (mq.size() != 0);
            fin  = 0;
            if (held && out_ready) begin
                fin = mq[0].last;
                void'(mq.pop_front());
            end
            if (gen_tick && (!held || fin)) begin
                for (int r = 0; r < HEIGHT; r++)
                    mq.push_back('{grid_status[r*WIDTH +: WIDTH], r, (r == HEIGHT - 1)});
                m_gen = (m_gen + 1) % (1 << GEN_W);
            end
            if (gen_tick && held && !fin) m_ovr = 1;
            else if (ovr_clr)             m_ovr = 0;
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("out_valid", out_valid, (mq.size() != 0));
            chk("busy", busy, (mq.size() != 0));
            chk("gen_count", gen_count, m_gen);
            chk("overrun", overrun, m_ovr);
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0].d);
                chk("out_row", out_row, mq[0].row);
                chk("out_last", out_last, mq[0].last);
            end else begin
                chk("out_last_idle", out_last, 0);
            end
        end
    end

    logic             pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int               erow [6] = '{0, 1, 1, 1, 2, 2};
    logic [WIDTH-1:0] edat [6] = '{4'h3, 4'h5, 4'h5, 4'h5, 4'hA, 4'hA};

    initial begin
        rst_b = 1'b0; grid_status = '0; gen_tick = 0; out_ready = 0; ovr_clr = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_ovr", overrun, 0);
        rst_b = 1'b1;
        cmp_en = 1;

        // 1: straight frame
        @(negedge clk); grid_status = 12'hA53; gen_tick = 1; out_ready = 1;
        @(negedge clk); gen_tick = 0; grid_status = 12'h000;
        chk("t1_d0", out_data, 4'h3); chk("t1_r0", out_row, 0); chk("t1_l0", out_last, 0);
        @(negedge clk);
        chk("t1_d1", out_data, 4'h5); chk("t1_r1", out_row, 1); chk("t1_l1", out_last, 0);
        @(negedge clk);
        chk("t1_d2", out_data, 4'hA); chk("t1_r2", out_row, 2); chk("t1_l2", out_last, 1);
        chk("t1_gen", gen_count, 1);
        @(negedge clk);
        chk("t1_busy", busy, 0);

        // 2: stalls
        grid_status = 12'hA53; gen_tick = 1; out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); gen_tick = 0;
            chk("t2_row", out_row, erow[i]);
            chk("t2_data", out_data, edat[i]);
            out_ready = pat[i];
        end
        @(negedge clk);
        chk("t2_busy", busy, 0); chk("t2_gen", gen_count, 2);

        // 3: dropped tick while row 1 stalled
        grid_status = 12'hA53; gen_tick = 1; out_ready = 1;
        @(negedge clk); gen_tick = 0;
        @(negedge clk); out_ready = 0; gen_tick = 1; grid_status = 12'hFFF;
        @(negedge clk); gen_tick = 0;
        chk("t3_ovr", overrun, 1); chk("t3_data", out_data, 4'h5);
        chk("t3_gen", gen_count, 3);
        ovr_clr = 1;
        @(negedge clk); ovr_clr = 0;
        chk("t3_clr", overrun, 0);
        out_ready = 1;
        repeat (3) @(negedge clk);

        // 4: back-to-back capture on final transfer
        grid_status = 12'hA53; gen_tick = 1; out_ready = 1;
        @(negedge clk); gen_tick = 0;
        @(negedge clk);
        @(negedge clk); chk("t4_last", out_last, 1); gen_tick = 1; grid_status = 12'h0F0;
        @(negedge clk); gen_tick = 0;
        chk("t4_valid", out_valid, 1); chk("t4_row", out_row, 0);
        chk("t4_data", out_data, 4'h0); chk("t4_gen", gen_count, 5);
        chk("t4_ovr", overrun, 0);
        @(negedge clk); chk("t4_d1", out_data, 4'hF);
        repeat (3) @(negedge clk);

        // 5: async reset mid-frame
        grid_status = 12'hA53; gen_tick = 1; out_ready = 0;
        @(negedge clk); gen_tick = 0; out_ready = 1;
        @(negedge clk); out_ready = 0;
        chk("t5_row", out_row, 1);
        #2 rst_b = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0); chk("t5_busy", busy, 0); chk("t5_gen", gen_count, 0);
        @(negedge clk); rst_b = 1'b1; out_ready = 1;
        repeat (5) begin
            @(negedge clk); chk("t5_quiet", out_valid, 0);
        end

        // 6: generation counter wrap
        for (int f = 1; f <= 16; f++) begin
            grid_status = 12'($urandom); gen_tick = 1; out_ready = 1;
            @(negedge clk); gen_tick = 0;
            repeat (3) @(negedge clk);
            if (f == 15) chk("t6_gen15", gen_count, 15);
            if (f == 16) chk("t6_wrap", gen_count, 0);
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            grid_status = 12'($urandom);
            gen_tick    = ($urandom_range(0, 4) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            ovr_clr     = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        gen_tick = 0; ovr_clr = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
